// File: rtl/rle_packet_sender_pkg.sv
// Shared types and constants for the RLE packet sender: FSM encoding,
// header word layouts, legal packet sizes and the CPU bus width.
package rle_packet_sender_pkg;

  localparam int WORD_WIDTH   = 32;
  localparam int PS_FIELD_W   = 6;
  localparam int ROWS_FIELD_W = 16;

  localparam logic [PS_FIELD_W-1:0] PSIZE_4  = 6'd4;
  localparam logic [PS_FIELD_W-1:0] PSIZE_8  = 6'd8;
  localparam logic [PS_FIELD_W-1:0] PSIZE_16 = 6'd16;
  localparam logic [PS_FIELD_W-1:0] PSIZE_32 = 6'd32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_PS,
    ST_HDR_ROWS,
    ST_FETCH,
    ST_WAIT_DATA,
    ST_SCAN,
    ST_ROW_END,
    ST_FLUSH,
    ST_DONE
  } state_t;

  function automatic logic psize_legal(input logic [PS_FIELD_W-1:0] ps);
    return (ps == PSIZE_4) || (ps == PSIZE_8) || (ps == PSIZE_16) || (ps == PSIZE_32);
  endfunction

  function automatic logic [WORD_WIDTH-1:0] hdr_ps_word(input logic [PS_FIELD_W-1:0] ps);
    return {{(WORD_WIDTH-PS_FIELD_W){1'b0}}, ps};
  endfunction

  function automatic logic [WORD_WIDTH-1:0] hdr_rows_word(input logic [ROWS_FIELD_W-1:0] rows);
    return {{(WORD_WIDTH-ROWS_FIELD_W){1'b0}}, rows};
  endfunction

endpackage

// File: rtl/rle_packet_sender_packer.sv
// Packs right-aligned P-bit packets MSB-first into 32-bit words through an
// assembly register feeding a single output register (double buffered).
module rle_word_packer
  import rle_packet_sender_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            psize,
  input  logic [WORD_WIDTH-1:0] pkt,
  input  logic                  pkt_valid,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic                  word_valid,
  input  logic                  flush,
  input  logic                  next_word,
  output logic [WORD_WIDTH-1:0] bus,
  output logic                  bus_valid,
  output logic                  ready,
  output logic                  empty
);

  logic [WORD_WIDTH-1:0] asm_word, asm_word_n, base_word, pkt_aligned;
  logic [5:0]            fill, fill_n, base_fill;
  logic                  asm_full, asm_full_n, load;

  // The output register takes the assembled word when it is free or being
  // consumed this very cycle, so the freed assembly slot can accept at once.
  assign load        = asm_full && (!bus_valid || next_word);
  assign ready       = !asm_full || load;
  assign empty       = !asm_full && (fill == '0) && !bus_valid;
  assign pkt_aligned = pkt << (6'(WORD_WIDTH) - psize);

  always_comb begin
    base_word  = load ? '0 : asm_word;
    base_fill  = load ? '0 : fill;
    asm_word_n = base_word;
    fill_n     = base_fill;
    asm_full_n = load ? 1'b0 : asm_full;
    if (word_valid) begin
      asm_word_n = word;
      asm_full_n = 1'b1;
    end else if (pkt_valid) begin
      asm_word_n = base_word | (pkt_aligned >> base_fill);
      fill_n     = base_fill + psize;
      asm_full_n = (fill_n == 6'(WORD_WIDTH));
    end else if (flush && !asm_full_n && (base_fill != '0)) begin
      asm_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_word  <= '0;
      fill      <= '0;
      asm_full  <= 1'b0;
      bus       <= '0;
      bus_valid <= 1'b0;
    end else begin
      asm_word <= asm_word_n;
      fill     <= fill_n;
      asm_full <= asm_full_n;
      if (load) begin
        bus       <= asm_word;
        bus_valid <= 1'b1;
      end else if (next_word) begin
        bus_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rle_packet_sender.sv
// Reads rows of 64-bit elements from RAM, run-length encodes each row into
// P-bit packets and streams them as 32-bit words after two header words.
module rle_packet_sender
  import rle_packet_sender_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Send_Enable,
  input  logic [5:0]               Packet_Size,
  input  logic [15:0]              Rows_Num,
  input  logic [11:0]              Elements_Per_Row,
  input  logic [ADDRESS_WIDTH-1:0] Base_Address,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic                     RAM_Read,
  input  logic [DATA_WIDTH-1:0]    RAM_Data,
  input  logic                     Next_Word,
  output logic [WORD_WIDTH-1:0]    CPU_Bus,
  output logic                     Bus_Valid,
  output logic                     Done_Sending
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  state_t                  state, state_n;
  logic [ADDRESS_WIDTH-1:0] addr_off;
  logic [DATA_WIDTH-1:0]   elem;
  logic [BIT_W-1:0]        bit_idx;
  logic [11:0]             elem_cnt;
  logic [15:0]             row_cnt;
  logic [31:0]             run_cnt, max_run, pkt_len;
  logic                    run_val, first_val, row_start, pend_zero, tail_zero, pkts_seen;
  logic                    cur_bit, last_bit, last_elem, last_row;
  logic                    pkt_valid, pkt_marker, word_valid, flush, split;
  logic [WORD_WIDTH-1:0]   word_data, pkt;
  logic                    ready, empty;

  assign RAM_Address  = Base_Address + addr_off;
  assign RAM_Read     = (state == ST_FETCH);
  assign Done_Sending = (state == ST_DONE);

  assign cur_bit   = elem[DATA_WIDTH-1];
  assign last_bit  = (bit_idx == '0);
  assign last_elem = (elem_cnt == Elements_Per_Row - 12'd1);
  assign last_row  = (row_cnt == Rows_Num - 16'd1);
  assign max_run   = (32'd1 << (Packet_Size - 6'd1)) - 32'd1;
  assign pkt       = (WORD_WIDTH'(pkt_marker) << (Packet_Size - 6'd1)) | pkt_len;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_n;
  end

  // A run reaching the field maximum with the same bit still pending is split:
  // emit max now, a zero-length packet next, and consume the bit afterwards.
  always_comb begin
    state_n    = state;
    pkt_valid  = 1'b0;
    pkt_marker = 1'b0;
    pkt_len    = '0;
    word_valid = 1'b0;
    word_data  = '0;
    flush      = 1'b0;
    split      = 1'b0;
    case (state)
      ST_IDLE: if (Send_Enable && psize_legal(Packet_Size)) state_n = ST_HDR_PS;
      ST_HDR_PS: if (ready) begin
        word_valid = 1'b1;
        word_data  = hdr_ps_word(Packet_Size);
        state_n    = ST_HDR_ROWS;
      end
      ST_HDR_ROWS: if (ready) begin
        word_valid = 1'b1;
        word_data  = hdr_rows_word(Rows_Num);
        state_n    = ST_FETCH;
      end
      ST_FETCH:     state_n = ST_WAIT_DATA;
      ST_WAIT_DATA: state_n = ST_SCAN;
      ST_SCAN: if (ready) begin
        pkt_marker = first_val;
        if (pend_zero) begin
          pkt_valid = 1'b1;
        end else if (!row_start && (cur_bit == run_val) && (run_cnt == max_run)) begin
          split     = 1'b1;
          pkt_valid = 1'b1;
          pkt_len   = run_cnt;
        end else begin
          if (!row_start && (cur_bit != run_val)) begin
            pkt_valid = 1'b1;
            pkt_len   = run_cnt;
          end
          if (last_bit) state_n = last_elem ? ST_ROW_END : ST_FETCH;
        end
      end
      ST_ROW_END: if (ready) begin
        pkt_valid = 1'b1;
        if (tail_zero) begin
          pkt_marker = ~first_val;
        end else begin
          pkt_len    = run_cnt;
          pkt_marker = pkts_seen ? ~first_val : first_val;
        end
        if (tail_zero || pkts_seen) state_n = last_row ? ST_FLUSH : ST_FETCH;
      end
      ST_FLUSH: begin
        if (empty) state_n = ST_DONE;
        else       flush   = 1'b1;
      end
      ST_DONE: state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_off  <= '0;
      elem      <= '0;
      bit_idx   <= '0;
      elem_cnt  <= '0;
      row_cnt   <= '0;
      run_cnt   <= '0;
      run_val   <= 1'b0;
      first_val <= 1'b0;
      row_start <= 1'b0;
      pend_zero <= 1'b0;
      tail_zero <= 1'b0;
      pkts_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          addr_off  <= '0;
          elem_cnt  <= '0;
          row_cnt   <= '0;
          run_cnt   <= '0;
          run_val   <= 1'b0;
          first_val <= 1'b0;
          row_start <= 1'b1;
          pend_zero <= 1'b0;
          tail_zero <= 1'b0;
          pkts_seen <= 1'b0;
        end
        ST_WAIT_DATA: begin
          elem     <= RAM_Data;
          bit_idx  <= BIT_W'(DATA_WIDTH - 1);
          addr_off <= addr_off + ADDRESS_WIDTH'(1);
        end
        ST_SCAN: if (ready) begin
          if (pend_zero) begin
            pend_zero <= 1'b0;
            run_cnt   <= '0;
          end else if (split) begin
            pend_zero <= 1'b1;
          end else begin
            elem    <= elem << 1;
            bit_idx <= bit_idx - BIT_W'(1);
            if (row_start || (cur_bit != run_val)) begin
              run_val <= cur_bit;
              run_cnt <= 32'd1;
            end else begin
              run_cnt <= run_cnt + 32'd1;
            end
            if (row_start) begin
              first_val <= cur_bit;
              row_start <= 1'b0;
            end
            if (last_bit) elem_cnt <= elem_cnt + 12'd1;
          end
          if (pkt_valid) pkts_seen <= 1'b1;
        end
        ST_ROW_END: if (ready) begin
          if (tail_zero || pkts_seen) begin
            tail_zero <= 1'b0;
            pkts_seen <= 1'b0;
            row_start <= 1'b1;
            row_cnt   <= row_cnt + 16'd1;
            elem_cnt  <= '0;
          end else begin
            tail_zero <= 1'b1;
            pkts_seen <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  rle_word_packer u_packer (
    .clk        (CLK),
    .rst_n      (RST),
    .psize      (Packet_Size),
    .pkt        (pkt),
    .pkt_valid  (pkt_valid),
    .word       (word_data),
    .word_valid (word_valid),
    .flush      (flush),
    .next_word  (Next_Word),
    .bus        (CPU_Bus),
    .bus_valid  (Bus_Valid),
    .ready      (ready),
    .empty      (empty)
  );

endmodule

// File: tb/tb_rle_packet_sender.sv
// Directed bench for rle_packet_sender: headers, packet encoding, splitting,
// stalls, a decode round-trip and mid-transfer reset.
module tb_rle_packet_sender;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam logic [AW-1:0] BASE = 13'h0A0;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Send_Enable;
  logic [5:0]    Packet_Size;
  logic [15:0]   Rows_Num;
  logic [11:0]   Elements_Per_Row;
  logic [AW-1:0] Base_Address;
  logic [AW-1:0] RAM_Address;
  logic          RAM_Read;
  logic [DW-1:0] RAM_Data;
  logic          Next_Word;
  logic [31:0]   CPU_Bus;
  logic          Bus_Valid;
  logic          Done_Sending;

  logic [DW-1:0] mem [0:63];
  logic [AW-1:0] ram_off;
  logic [31:0]   words[$];
  int            errors = 0;
  int            checks = 0;
  logic          timed_out;
  logic          stall_stable;
  logic          stall_hit;

  always #5 CLK = ~CLK;

  assign ram_off = RAM_Address - BASE;
  always_ff @(posedge CLK) if (RAM_Read) RAM_Data <= mem[ram_off[5:0]];

  rle_packet_sender dut (
    .CLK              (CLK),
    .RST              (RST),
    .Send_Enable      (Send_Enable),
    .Packet_Size      (Packet_Size),
    .Rows_Num         (Rows_Num),
    .Elements_Per_Row (Elements_Per_Row),
    .Base_Address     (Base_Address),
    .RAM_Address      (RAM_Address),
    .RAM_Read         (RAM_Read),
    .RAM_Data         (RAM_Data),
    .Next_Word        (Next_Word),
    .CPU_Bus          (CPU_Bus),
    .Bus_Valid        (Bus_Valid),
    .Done_Sending     (Done_Sending)
  );

  task automatic do_reset;
    RST = 1'b0;
    Send_Enable = 1'b0;
    Next_Word = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // Starts a job and collects every consumed word; stall_at >= 0 holds
  // Next_Word low for 20 cycles once that many words have been taken.
  task automatic run_job(input int ps, input int rows, input int epr, input int stall_at);
    int stall_left;
    logic [31:0] snap;
    words.delete();
    Packet_Size = 6'(ps);
    Rows_Num = 16'(rows);
    Elements_Per_Row = 12'(epr);
    Send_Enable = 1'b1;
    @(negedge CLK);
    Send_Enable = 1'b0;
    stall_left = 0;
    stall_hit = 1'b0;
    stall_stable = 1'b1;
    snap = '0;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (Done_Sending) begin
        timed_out = 1'b0;
        break;
      end
      if (!stall_hit && stall_at >= 0 && words.size() == stall_at && Bus_Valid) begin
        stall_left = 20;
        stall_hit = 1'b1;
        snap = CPU_Bus;
      end
      if (stall_left > 0) begin
        Next_Word = 1'b0;
        if (CPU_Bus !== snap || Bus_Valid !== 1'b1) stall_stable = 1'b0;
        stall_left--;
      end else begin
        Next_Word = 1'b1;
      end
      if (Bus_Valid && Next_Word) words.push_back(CPU_Bus);
      @(negedge CLK);
    end
    Next_Word = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    Send_Enable = 1'b0;
    Next_Word = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (CPU_Bus !== 32'h0) begin errors++; $display("FAIL reset_bus got=%h want=0", CPU_Bus); end
    checks++; if (Bus_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", Bus_Valid); end
    checks++; if (Done_Sending !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", Done_Sending); end
    checks++; if (RAM_Read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b want=0", RAM_Read); end
    checks++; if (RAM_Address !== BASE) begin errors++; $display("FAIL reset_addr got=%h want=%h", RAM_Address, BASE); end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_zero_row;
    logic [31:0] exp[3] = '{32'h8, 32'h1, 32'h40800000};
    mem[0] = 64'h0;
    do_reset();
    run_job(8, 1, 1, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout got=timeout want=done"); end
    checks++; if (words.size() != 3) begin errors++; $display("FAIL zero_count got=%0d want=3", words.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= words.size() || words[i] !== exp[i]) begin
        errors++; $display("FAIL zero_word%0d got=%h want=%h", i, (i < words.size()) ? words[i] : 32'hx, exp[i]);
      end
    end
    checks++; if (Done_Sending !== 1'b1) begin errors++; $display("FAIL zero_done got=%b want=1", Done_Sending); end
  endtask

  task automatic test_half_row;
    logic [31:0] exp[3] = '{32'h8, 32'h1, 32'hA0200000};
    mem[0] = 64'hFFFFFFFF00000000;
    do_reset();
    run_job(8, 1, 1, -1);
    checks++; if (words.size() != 3) begin errors++; $display("FAIL half_count got=%0d want=3", words.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= words.size() || words[i] !== exp[i]) begin
        errors++; $display("FAIL half_word%0d got=%h want=%h", i, (i < words.size()) ? words[i] : 32'hx, exp[i]);
      end
    end
  endtask

  task automatic test_long_run;
    logic [31:0] exp[5] = '{32'h4, 32'h1, 32'hF8F8F8F8, 32'hF8F8F8F8, 32'hF8100000};
    mem[0] = 64'hFFFFFFFFFFFFFFFF;
    do_reset();
    run_job(4, 1, 1, -1);
    checks++; if (words.size() != 5) begin errors++; $display("FAIL long_count got=%0d want=5", words.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= words.size() || words[i] !== exp[i]) begin
        errors++; $display("FAIL long_word%0d got=%h want=%h", i, (i < words.size()) ? words[i] : 32'hx, exp[i]);
      end
    end
  endtask

  task automatic test_roundtrip_stall;
    logic [31:0] ref_words[$];
    logic [127:0] rowbits;
    logic [31:0] w, p;
    logic m, v;
    int k, npk, nbits, flips, diffs;
    mem[0] = 64'hDEADBEEF01234567;
    mem[1] = 64'h0F0F33CCA5A5FFFF;
    mem[2] = 64'h8000000000000001;
    mem[3] = 64'hCAFEF00D7E57B0A1;
    do_reset();
    run_job(8, 2, 2, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL rt_timeout got=timeout want=done"); end
    checks++; if (words.size() < 2 || words[0] !== 32'h8 || words[1] !== 32'h2) begin
      errors++; $display("FAIL rt_headers got=%h,%h want=00000008,00000002",
        (words.size() > 0) ? words[0] : 32'hx, (words.size() > 1) ? words[1] : 32'hx);
    end
    ref_words = words;
    npk = (words.size() > 2) ? (words.size() - 2) * 4 : 0;
    k = 0;
    flips = 0;
    for (int r = 0; r < 2; r++) begin
      rowbits = '0;
      nbits = 0;
      m = 1'b0;
      v = 1'b0;
      for (int j = 0; j < 400 && k < npk; j++) begin
        w = words[2 + k / 4];
        p = (w >> (24 - 8 * (k % 4))) & 32'hFF;
        k++;
        if (j == 0) begin m = p[7]; v = p[7]; end
        for (int b = 0; b < int'(p[6:0]); b++) begin
          if (nbits < 128) rowbits[127 - nbits] = v;
          nbits++;
        end
        v = ~v;
        if (p[7] != m) begin flips++; break; end
      end
      checks++; if (rowbits[127:64] !== mem[2*r]) begin errors++; $display("FAIL rt_elem%0d got=%h want=%h", 2*r, rowbits[127:64], mem[2*r]); end
      checks++; if (rowbits[63:0] !== mem[2*r+1]) begin errors++; $display("FAIL rt_elem%0d got=%h want=%h", 2*r+1, rowbits[63:0], mem[2*r+1]); end
    end
    checks++; if (flips != 2) begin errors++; $display("FAIL rt_flips got=%0d want=2", flips); end
    do_reset();
    run_job(8, 2, 2, 4);
    checks++; if (timed_out || !stall_hit) begin errors++; $display("FAIL stall_run got=timeout%0b/hit%0b want=0/1", timed_out, stall_hit); end
    checks++; if (!stall_stable) begin errors++; $display("FAIL stall_hold got=changed want=stable"); end
    diffs = (words.size() == ref_words.size()) ? 0 : 1;
    for (int i = 0; i < words.size() && i < ref_words.size(); i++) if (words[i] !== ref_words[i]) diffs++;
    checks++; if (diffs != 0) begin errors++; $display("FAIL stall_stream got=%0d diffs (%0d words) want=0 (%0d words)", diffs, words.size(), ref_words.size()); end
  endtask

  task automatic test_reset_mid;
    int seen;
    mem[0] = 64'h123456789ABCDEF0;
    mem[1] = 64'h0;
    do_reset();
    Packet_Size = 6'd8;
    Rows_Num = 16'd1;
    Elements_Per_Row = 12'd2;
    Next_Word = 1'b1;
    Send_Enable = 1'b1;
    @(negedge CLK);
    Send_Enable = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 50 && seen == 0; cyc++) begin
      if (RAM_Read) seen = 1;
      @(negedge CLK);
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL mid_fetch got=no_read want=read"); end
    repeat (6) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++; if (CPU_Bus !== 32'h0) begin errors++; $display("FAIL mid_bus got=%h want=0", CPU_Bus); end
    checks++; if (Bus_Valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b want=0", Bus_Valid); end
    checks++; if (RAM_Read !== 1'b0) begin errors++; $display("FAIL mid_read got=%b want=0", RAM_Read); end
    checks++; if (RAM_Address !== BASE) begin errors++; $display("FAIL mid_addr got=%h want=%h", RAM_Address, BASE); end
    Next_Word = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    run_job(8, 1, 2, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL mid_timeout got=timeout want=done"); end
    checks++; if (words.size() < 2 || words[0] !== 32'h8 || words[1] !== 32'h1) begin
      errors++; $display("FAIL mid_headers got=%h,%h want=00000008,00000001",
        (words.size() > 0) ? words[0] : 32'hx, (words.size() > 1) ? words[1] : 32'hx);
    end
    checks++; if (Done_Sending !== 1'b1) begin errors++; $display("FAIL mid_done got=%b want=1", Done_Sending); end
  endtask

  initial begin
    RST = 1'b0;
    Send_Enable = 1'b0;
    Next_Word = 1'b0;
    Packet_Size = 6'd8;
    Rows_Num = 16'd1;
    Elements_Per_Row = 12'd1;
    Base_Address = BASE;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_zero_row();
    test_half_row();
    test_long_run();
    test_roundtrip_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rle_packet_sender.md
Name: rle_packet_sender

Overview:
- Upstream stage of the CPU-bus receive/decoder path.
- Reads 64-bit elements row by row from a source RAM and run-length encodes each row's bit-stream into fixed-size packets.
- Packs the packets MSB-first into 32-bit words and drives them onto CPU_Bus under the word-request handshake issued by the decoder.
- Sends two header words first: packet size, then row count.

Parameters:
- ADDRESS_WIDTH, 13, source RAM address width
- DATA_WIDTH, 64, element width in bits
- WORD_WIDTH, 32, CPU bus width

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-low reset
- Send_Enable  in  1  level; start sampled in IDLE
- Packet_Size  in  6  packet width P; legal values 4, 8, 16, 32; held stable while busy
- Rows_Num  in  16  number of rows to send (≥1)
- Elements_Per_Row  in  12  64-bit elements per row (≥1)
- Base_Address  in  ADDRESS_WIDTH  address of first element; rows are contiguous
- RAM_Address  out  ADDRESS_WIDTH  source read address
- RAM_Read  out  1  read strobe
- RAM_Data  in  DATA_WIDTH  read data, valid exactly 1 cycle after RAM_Read
- Next_Word  in  1  decoder request for the next word (decoder's done-processing-packet output)
- CPU_Bus  out  32  current word
- Bus_Valid  out  1  CPU_Bus holds a word
- Done_Sending  out  1  sticky completion flag

Behaviour:
- Reset (RST=0, async): CPU_Bus=0, Bus_Valid=0, Done_Sending=0, RAM_Read=0, RAM_Address=Base_Address. FSM goes to IDLE; all counters, the assembly word and the run state clear. Reset mid-transfer aborts with no flush.
- FSM: IDLE → HDR_PS → HDR_ROWS → FETCH → WAIT_DATA → SCAN → (FETCH | ROW_END) → … → FLUSH → DONE.
  - IDLE: Send_Enable=1 → HDR_PS.
  - HDR_PS: CPU_Bus={26'b0, Packet_Size}.
  - HDR_ROWS: CPU_Bus={16'b0, Rows_Num}.
- Word handshake: a word on CPU_Bus is consumed in any cycle where Bus_Valid=1 and Next_Word=1. The next word appears no earlier than the following cycle. Bus_Valid drops while no word is ready.
- Double buffering: one output register plus one assembly register. If the assembly register is full and the output register is unconsumed, the scanner stalls; no bit or packet is ever lost.
- FETCH/WAIT_DATA: pulse RAM_Read for one cycle, capture RAM_Data the next cycle, then increment RAM_Address.
- SCAN: one bit per cycle, MSB first.
  - A run is the count of consecutive equal bits. Runs cross element boundaries within a row and restart at each row boundary.
  - Run length field is P-1 bits, so max run = 2^(P-1)-1.
  - A longer run is emitted as max, then a 0-length run of the opposite value, then the remainder; repeat as needed.
- Packet = {marker, run_length[P-2:0]}.
  - Row's first packet: marker = value of the row's first bit.
  - Middle packets: same marker as the first packet.
  - Last packet of the row: inverted marker.
  - Runs alternate value starting from the first-bit value.
  - If a row yields only one run, append a 0-length packet as the last packet.
- Packing: packets fill the assembly word from bit 31 downward, 32/P packets per word, with no gaps. Rows do not start new words.
- FLUSH: after the last row's last packet, a partially filled word is padded with 0s in the low bits and sent.
- DONE: Done_Sending=1 after the final word is consumed. It stays high until reset; Send_Enable is ignored.
- Simultaneous consume and new assembly-word completion in one cycle: output register reloads the same cycle with no bubble.
- Illegal Packet_Size: behaviour undefined; the bench does not drive it.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - Header word layouts (packet size in bits [5:0], rows in [15:0]).
  - Legal packet sizes.
  - WORD_WIDTH.
- One natural sub-module, rle_word_packer: accepts {P-bit packet, valid}, left-aligns and packs into 32-bit words, exposes full/stall, and handles flush padding.

Test Plan:
- P=8, Rows_Num=1, Epr=1, element 0 → words 0x00000008, 0x00000001, 0x40800000; Done_Sending=1.
- P=8, 1×1, element 0xFFFFFFFF00000000 → payload word 0xA0200000.
- P=4, 1×1, element all ones → 64 split as nine 7-runs plus one 1-run with 0-runs between: 19 packets, last packet marker inverted, 3 words (last padded).
- Next_Word held low 20 cycles mid-stream → CPU_Bus/Bus_Valid stable, no packet lost; byte-identical output versus an unstalled run.
- P=8, 2 rows × 2 elements, random data → decoder-model round-trip reproduces all 4 elements; row-boundary marker flips seen exactly twice.
- RST asserted during SCAN → outputs return to reset values immediately; a new Send_Enable restarts with header words.
